ball_locate: RTL and testbench
==============================

# ball_locate

Per-frame colour-blob locator downstream of the RGB565→YCbCr converter. Each pixel's Cb/Cr pair is classified against a programmable chroma window, producing a binary mask stream for display and debug. It accumulates the bounding box, centre and hit count of in-window pixels over each frame, and publishes them once per frame at the vsync rising edge to the tracking/overlay logic.

## Interface
- CB_MIN, 8'h30: Cb lower bound (exclusive)
- CB_MAX, 8'h80: Cb upper bound (exclusive)
- CR_MIN, 8'hC8: Cr lower bound (exclusive)
- CR_MAX, 8'hFF: Cr upper bound (exclusive)
- MIN_PIXELS, 64: minimum hit count for a frame to report a ball
- CW, 11: coordinate width (max coordinate 2^CW−1)
- clk  in  1  pixel clock; single clock domain
- rst  in  1  synchronous, active-high reset
- pre_frame_vsync  in  1  frame sync; rising edge = frame boundary
- pre_frame_hsync  in  1  line sync (passed through only)
- pre_frame_de  in  1  pixel valid
- img_y, img_cb, img_cr  in  8 each  pixel components (img_y unused except passthrough-free; ignored)
- post_frame_vsync, post_frame_hsync, post_frame_de  out  1 each  inputs delayed 1 cycle
- mask_data  out  8  8'hFF on hit, else 8'h00
- ball_x_min, ball_x_max, ball_y_min, ball_y_max  out  CW each  published bounding box
- ball_xc, ball_yc  out  CW each  published box centre
- ball_pixels  out  20  published hit count (saturating)
- ball_found  out  1  published count ≥ MIN_PIXELS
- frame_done  out  1  one-cycle strobe when results are published

## Operation
- hit = de & (cb > CB_MIN) & (cb < CB_MAX) & (cr > CR_MIN) & (cr < CR_MAX). All comparisons are unsigned and strict.
- Position counters:
  - x_cnt increments on every de-high cycle.
  - On a de falling edge, x_cnt clears and y_cnt increments.
  - Both counters clear on a vsync rising edge.
  - Both counters saturate at 2^CW−1.
- The coordinate of a pixel is the (x_cnt, y_cnt) value before that cycle's increment, so the first pixel of a frame is (0,0).
- Accumulators: xmin/ymin initialise to all-ones, xmax/ymax to 0, and count to 0. On each hit: min/max update, and count increments, saturating at 20'hFFFFF.
- Arming FSM, states IDLE → RUN:
  - After reset the state is IDLE.
  - In IDLE, the first vsync rising edge clears the accumulators and moves to RUN. Nothing is published and there is no frame_done.
  - In RUN, every vsync rising edge publishes and then clears the accumulators.
- Publish:
  - ball_pixels is set to count.
  - If count ≥ MIN_PIXELS: ball_found=1; box outputs take the accumulator values; ball_xc = (xmin+xmax)>>1 and ball_yc = (ymin+ymax)>>1, computed with a CW+1-bit sum.
  - Otherwise ball_found=0 and the box and centre outputs hold their previous values.
- A hit coincident with a vsync rising edge is discarded; the frame boundary has priority.

## Timing
- Reset values: every output 0, state IDLE, accumulators at their initial values.
- The mask path has a latency of exactly 1 cycle: mask_data and post_frame_* are registered together. mask_data is 0 whenever the registered de is 0.
- Edge detection uses a 1-cycle registered copy of vsync and de.
- At the clock edge where vsync is sampled 1 after having been sampled 0, the following happen in the same edge:
  - the results are published;
  - frame_done goes high for exactly 1 cycle;
  - the accumulators clear.
- Published outputs are stable between frame_done strobes.
- Asserting rst mid-frame returns the block to IDLE. The partial frame after reset is never published.

## Test plan
- Reset then constant stimulus: hold rst 3 cycles, then cb=8'h50, cr=8'hE0 with de high → mask_data=8'hFF one cycle after each de, and all published outputs stay 0 until the first frame_done.
- Blob frame: 16×8 frame with 2 idle cycles between lines. Hits at x 4..7, y 2..5; all other pixels cb=cr=8'h80. Use MIN_PIXELS=16. Preceded by an arming vsync edge → frame_done with box (4,7,2,5), centre (5,3), ball_pixels=16, ball_found=1.
- Sub-threshold frame: the same blob with MIN_PIXELS=17 → ball_found=0, ball_pixels=16, and the box/centre hold the previous frame's values.
- Window boundaries: cb=8'h30 or 8'h80, or cr=8'hC8 or 8'hFF → no hit. cb=8'h31 with cr=8'hC9 → hit.
- Vsync priority: a hit pixel driven on the vsync rising-edge cycle is not counted in either the old or the new frame.
- Arming and mid-frame reset: the first vsync edge after reset produces no frame_done. Asserting rst mid-frame, then sending two frames, yields exactly one frame_done.

Source files
------------

// File: rtl/ball_locate.sv
// ball_locate: chroma-window blob locator; per-frame bounding box, centre, hit count published at vsync rise
module ball_locate #(
  parameter logic [7:0] CB_MIN = 8'h30,
  parameter logic [7:0] CB_MAX = 8'h80,
  parameter logic [7:0] CR_MIN = 8'hC8,
  parameter logic [7:0] CR_MAX = 8'hFF,
  parameter int MIN_PIXELS = 64,
  parameter int CW = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic pre_frame_vsync,
  input  logic pre_frame_hsync,
  input  logic pre_frame_de,
  input  logic [7:0] img_y,
  input  logic [7:0] img_cb,
  input  logic [7:0] img_cr,
  output logic post_frame_vsync,
  output logic post_frame_hsync,
  output logic post_frame_de,
  output logic [7:0] mask_data,
  output logic [CW-1:0] ball_x_min,
  output logic [CW-1:0] ball_x_max,
  output logic [CW-1:0] ball_y_min,
  output logic [CW-1:0] ball_y_max,
  output logic [CW-1:0] ball_xc,
  output logic [CW-1:0] ball_yc,
  output logic [19:0] ball_pixels,
  output logic ball_found,
  output logic frame_done
);
  localparam logic [CW-1:0] MAXC = '1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state, w_state_nxt;
  logic r_vs, r_de, w_vs_rise, w_de_fall, w_hit, w_publish, w_found, w_unused;
  logic [CW-1:0] r_x, r_y, r_xmin, r_xmax, r_ymin, r_ymax;
  logic [19:0] r_cnt;
  logic [CW:0] w_xsum, w_ysum;
  assign w_unused = ^img_y;
  assign w_vs_rise = pre_frame_vsync & ~r_vs;
  assign w_de_fall = r_de & ~pre_frame_de;
  assign w_hit = pre_frame_de & (img_cb > CB_MIN) & (img_cb < CB_MAX) & (img_cr > CR_MIN) & (img_cr < CR_MAX);
  assign w_found = r_cnt >= 20'(MIN_PIXELS);
  assign w_xsum = {1'b0, r_xmin} + {1'b0, r_xmax};
  assign w_ysum = {1'b0, r_ymin} + {1'b0, r_ymax};
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  always_comb begin
    w_state_nxt = w_vs_rise ? RUN : r_state;
    w_publish = w_vs_rise & (r_state == RUN);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs <= 1'b0;
      r_de <= 1'b0;
      post_frame_vsync <= 1'b0;
      post_frame_hsync <= 1'b0;
      post_frame_de <= 1'b0;
      mask_data <= 8'h00;
    end else begin
      r_vs <= pre_frame_vsync;
      r_de <= pre_frame_de;
      post_frame_vsync <= pre_frame_vsync;
      post_frame_hsync <= pre_frame_hsync;
      post_frame_de <= pre_frame_de;
      mask_data <= w_hit ? 8'hFF : 8'h00;
    end
  end
  // a de falling edge ends a line; the coordinate of a pixel is the count before its increment
  always_ff @(posedge clk) begin
    if (rst || w_vs_rise) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_de_fall) begin
      r_x <= '0;
      r_y <= (r_y == MAXC) ? r_y : r_y + CW'(1);
    end else if (pre_frame_de && r_x != MAXC) begin
      r_x <= r_x + CW'(1);
    end
  end
  // the frame boundary wins over a coincident hit, so that pixel lands in neither frame
  always_ff @(posedge clk) begin
    if (rst || w_vs_rise) begin
      r_xmin <= MAXC;
      r_ymin <= MAXC;
      r_xmax <= '0;
      r_ymax <= '0;
      r_cnt <= '0;
    end else if (w_hit) begin
      r_xmin <= (r_x < r_xmin) ? r_x : r_xmin;
      r_xmax <= (r_x > r_xmax) ? r_x : r_xmax;
      r_ymin <= (r_y < r_ymin) ? r_y : r_ymin;
      r_ymax <= (r_y > r_ymax) ? r_y : r_ymax;
      r_cnt <= (r_cnt == 20'hFFFFF) ? r_cnt : r_cnt + 20'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done <= 1'b0;
      ball_pixels <= '0;
      ball_found <= 1'b0;
      ball_x_min <= '0;
      ball_x_max <= '0;
      ball_y_min <= '0;
      ball_y_max <= '0;
      ball_xc <= '0;
      ball_yc <= '0;
    end else begin
      frame_done <= w_publish;
      if (w_publish) begin
        ball_pixels <= r_cnt;
        ball_found <= w_found;
      end
      if (w_publish && w_found) begin
        ball_x_min <= r_xmin;
        ball_x_max <= r_xmax;
        ball_y_min <= r_ymin;
        ball_y_max <= r_ymax;
        ball_xc <= w_xsum[CW:1];
        ball_yc <= w_ysum[CW:1];
      end
    end
  end
endmodule

// File: tb/tb_ball_locate.sv
// tb_ball_locate: scoreboard bench for ball_locate with directed frames
module tb_ball_locate;
  typedef struct packed {
    logic [19:0] pix;
    logic found;
    logic [10:0] x0, x1, y0, y1, xc, yc;
  } res_t;
  logic clk = 0, rst = 1, vs = 0, hs = 0, de = 0;
  logic [7:0] cb = 0, cr = 0, yy = 0;
  logic a_pv, a_ph, a_pd, a_found, a_fd, b_pv, b_ph, b_pd, b_found, b_fd;
  logic [7:0] a_mask, b_mask;
  logic [10:0] a_x0, a_x1, a_y0, a_y1, a_xc, a_yc, b_x0, b_x1, b_y0, b_y1, b_xc, b_yc;
  logic [19:0] a_pix, b_pix;
  res_t qa[$], qb[$];
  logic [8:0] mq[$];
  int nvec = 0, nerr = 0, fd_a = 0;
  always #5 clk = ~clk;
  ball_locate #(.MIN_PIXELS(16)) dut_a (
    .clk(clk), .rst(rst), .pre_frame_vsync(vs), .pre_frame_hsync(hs), .pre_frame_de(de),
    .img_y(yy), .img_cb(cb), .img_cr(cr), .post_frame_vsync(a_pv), .post_frame_hsync(a_ph),
    .post_frame_de(a_pd), .mask_data(a_mask), .ball_x_min(a_x0), .ball_x_max(a_x1),
    .ball_y_min(a_y0), .ball_y_max(a_y1), .ball_xc(a_xc), .ball_yc(a_yc),
    .ball_pixels(a_pix), .ball_found(a_found), .frame_done(a_fd));
  ball_locate #(.MIN_PIXELS(17)) dut_b (
    .clk(clk), .rst(rst), .pre_frame_vsync(vs), .pre_frame_hsync(hs), .pre_frame_de(de),
    .img_y(yy), .img_cb(cb), .img_cr(cr), .post_frame_vsync(b_pv), .post_frame_hsync(b_ph),
    .post_frame_de(b_pd), .mask_data(b_mask), .ball_x_min(b_x0), .ball_x_max(b_x1),
    .ball_y_min(b_y0), .ball_y_max(b_y1), .ball_xc(b_xc), .ball_yc(b_yc),
    .ball_pixels(b_pix), .ball_found(b_found), .frame_done(b_fd));
  function automatic res_t act_a();
    return {a_pix, a_found, a_x0, a_x1, a_y0, a_y1, a_xc, a_yc};
  endfunction
  function automatic res_t act_b();
    return {b_pix, b_found, b_x0, b_x1, b_y0, b_y1, b_xc, b_yc};
  endfunction
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (a_fd) begin
      fd_a++;
      if (qa.size() == 0) check("unexpected frame_done a", 1, 0);
      else check("publish a", 128'(act_a()), 128'(qa.pop_front()));
    end
    if (b_fd) begin
      if (qb.size() == 0) check("unexpected frame_done b", 1, 0);
      else check("publish b", 128'(act_b()), 128'(qb.pop_front()));
    end
    if (a_pd) begin
      if (mq.size() == 0) check("unexpected pixel", 1, 0);
      else begin
        logic [8:0] m;
        m = mq.pop_front();
        check("mask a", {a_ph, a_mask}, 128'(m));
        check("mask b", {b_ph, b_mask, b_pd}, 128'({m, 1'b1}));
      end
    end
  end
  task automatic drive(input logic v, input logic d, input logic [7:0] b, input logic [7:0] r);
    @(negedge clk);
    rst = 0; vs = v; de = d; hs = d; cb = b; cr = r;
    if (d) mq.push_back({1'b1, (b > 8'h30 && b < 8'h80 && r > 8'hC8 && r < 8'hFF) ? 8'hFF : 8'h00});
  endtask
  task automatic do_reset(input int n);
    repeat (n) begin
      @(negedge clk);
      rst = 1; vs = 0; de = 0; hs = 0;
    end
  endtask
  task automatic vsync_edge(input logic hitpix, input logic pub, input res_t ea, input res_t eb);
    drive(1, hitpix, 8'h50, 8'hE0);
    if (pub) begin
      qa.push_back(ea);
      qb.push_back(eb);
    end
    drive(1, 0, 8'h80, 8'h80);
    drive(0, 0, 8'h80, 8'h80);
    drive(0, 0, 8'h80, 8'h80);
  endtask
  task automatic frame(input int x0, input int x1, input int y0, input int y1, input int lines);
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < 16; x++) begin
        logic h;
        h = x >= x0 && x <= x1 && y >= y0 && y <= y1;
        drive(0, 1, h ? 8'h50 : 8'h80, h ? 8'hE0 : 8'h80);
      end
      drive(0, 0, 8'h80, 8'h80);
      drive(0, 0, 8'h80, 8'h80);
    end
  endtask
  res_t z = '0;
  res_t blob_a = {20'd16, 1'b1, 11'd4, 11'd7, 11'd2, 11'd5, 11'd5, 11'd3};
  res_t blob_b = {20'd16, 1'b0, 66'd0};
  res_t big = {20'd54, 1'b1, 11'd2, 11'd10, 11'd1, 11'd6, 11'd6, 11'd3};
  initial begin
    int base;
    do_reset(3);
    check("reset a", {act_a(), a_fd, a_mask, a_pv, a_ph, a_pd}, 0);
    check("reset b", {act_b(), b_fd, b_mask, b_pv, b_ph, b_pd}, 0);
    repeat (6) drive(0, 1, 8'h50, 8'hE0);
    drive(0, 0, 8'h80, 8'h80);
    drive(0, 0, 8'h80, 8'h80);
    check("idle outputs a", 128'(act_a()), 0);
    check("idle outputs b", 128'(act_b()), 0);
    vsync_edge(0, 0, z, z);
    check("armed no publish a", 128'(act_a()), 0);
    frame(4, 7, 2, 5, 8);
    vsync_edge(0, 1, blob_a, blob_b);
    frame(2, 10, 1, 6, 8);
    vsync_edge(0, 1, big, big);
    frame(4, 7, 2, 5, 8);
    vsync_edge(0, 1, blob_a, {20'd16, 1'b0, big[65:0]});
    drive(0, 1, 8'h30, 8'hE0);
    drive(0, 1, 8'h80, 8'hE0);
    drive(0, 1, 8'h50, 8'hC8);
    drive(0, 1, 8'h50, 8'hFF);
    drive(0, 1, 8'h31, 8'hC9);
    drive(0, 1, 8'h7F, 8'hFE);
    drive(0, 0, 8'h80, 8'h80);
    drive(0, 0, 8'h80, 8'h80);
    vsync_edge(1, 1, {20'd2, 1'b0, blob_a[65:0]}, {20'd2, 1'b0, big[65:0]});
    frame(20, 20, 20, 20, 2);
    vsync_edge(0, 1, {20'd0, 1'b0, blob_a[65:0]}, {20'd0, 1'b0, big[65:0]});
    frame(4, 7, 2, 5, 4);
    do_reset(2);
    base = fd_a;
    vsync_edge(0, 0, z, z);
    frame(4, 7, 2, 5, 8);
    vsync_edge(0, 1, blob_a, blob_b);
    frame(4, 7, 2, 5, 8);
    repeat (4) drive(0, 0, 8'h80, 8'h80);
    check("frame_done count after reset", 128'(fd_a - base), 1);
    check("queues drained", 128'({qa.size(), qb.size(), mq.size()}), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
